freq_meter: RTL and testbench
=============================

// Module: freq_meter
// PURPOSE
//  Measures the frequency of an incoming clock-like signal (e.g. a divided clock or an
//  ADXL345 INT/data-ready line) by counting its rising edges over a fixed gate window
//  timed from clk_i. Counterpart to the clock dividers: verifies a divided rate on-chip.
//  Result is presented with a one-cycle valid strobe for logging or a 7-seg display.
// PARAMETERS
//  GATE_CYCLES  50_000_000  gate window length in clk_i cycles (1 s at 50 MHz)
//  CNT_W        32          width of edge counter / count_o
//  SYNC_STAGES  2           synchronizer flops on sig_i (>=2)
// PORTS
//  clk_i      in   1      system clock
//  rst_ni     in   1      synchronous reset, active-low
//  sig_i      in   1      asynchronous signal under measurement
//  start_i    in   1      pulse: begin one measurement (sampled in IDLE only)
//  cont_i     in   1      1 = re-arm automatically after each result
//  count_o    out  CNT_W  rising edges counted in last completed gate
//  valid_o    out  1      one-cycle strobe, count_o/ovf_o updated this cycle
//  busy_o     out  1      measurement in progress (state != IDLE)
//  ovf_o      out  1      last count saturated at 2^CNT_W-1
// BEHAVIOUR
//  - One clock (clk_i); reset synchronous, active-low (rst_ni). All state updates on posedge clk_i.
//  - Reset (rst_ni=0 at a clock edge): state=IDLE, count_o=0, valid_o=0, busy_o=0, ovf_o=0,
//    gate timer=0, edge counter=0, sync chain=0. Reset mid-gate aborts; no valid_o issued.
//  - sig_i passes SYNC_STAGES flops then one history flop; edge = sync & ~hist (1-cycle pulse).
//    Fixed pipeline offset of SYNC_STAGES+1 cycles; does not change counted rate.
//  - Max countable rate clk_i/2 (sig_i toggling every cycle -> edge every 2 cycles).
//  - FSM states: IDLE, GATE, DONE.
//    IDLE: start_i=1 or cont_i=1 -> GATE; clear edge counter and timer.
//    GATE: exactly GATE_CYCLES cycles; each cycle with edge=1 increments counter
//          (saturating at 2^CNT_W-1, sets internal ovf flag). Timer==GATE_CYCLES-1 -> DONE.
//    DONE: one cycle; count_o<=counter, ovf_o<=flag, valid_o=1.
//          cont_i=1 -> GATE (counters cleared), else -> IDLE.
//  - Latency: start_i at cycle 0 -> busy_o=1 at cycle 1, GATE cycles 1..GATE_CYCLES,
//    valid_o=1 at cycle GATE_CYCLES+1. Continuous: valid_o every GATE_CYCLES+1 cycles.
//  - Edge in the DONE cycle or in IDLE is not counted (gate-exclusive).
//  - start_i while busy_o=1 ignored. cont_i deasserted mid-gate: current gate completes,
//    then IDLE. count_o/ovf_o hold between valid_o strobes.
//  - Timer width = $clog2(GATE_CYCLES); GATE_CYCLES>=2 required.
// CONFIGURATION
//  Macro FREQ_METER_PERIOD_EN:
//   defined: extra port period_o out CNT_W = clk_i cycles between the last two edges
//     seen within the gate, latched with valid_o; 0 if fewer than 2 edges in gate;
//     saturates at 2^CNT_W-1. Reset value 0.
//   undefined: period_o port and its counter absent; all other behaviour identical.
// TESTING (GATE_CYCLES=100, CNT_W=32 unless stated)
//  1. sig_i square period 10 clk, start_i pulse -> valid_o at cycle 101, count_o=10, ovf_o=0.
//  2. sig_i held 0 (and held 1), start_i -> count_o=0, valid_o once, busy_o back to 0.
//  3. sig_i toggling every clk (clk/2) -> count_o=50.
//  4. CNT_W=4, sig_i period 5 (20 edges) -> count_o=15, ovf_o=1.
//  5. rst_ni=0 at cycle 50 of gate -> next cycle all outputs 0, no valid_o for that gate.
//  6. cont_i=1, period 4 -> valid_o every 101 cycles, count_o=25 each; with
//     FREQ_METER_PERIOD_EN, period_o=4; start_i pulses during GATE have no effect.

Source files
------------

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of asynchronous sig_i over a GATE_CYCLES window of clk_i.
// Latency: start_i sampled at cycle 0 -> valid_o at cycle GATE_CYCLES+1; sig_i sees SYNC_STAGES+1 cycles of offset.
// Backpressure: none; valid_o is a one-cycle strobe and start_i is ignored while busy_o is high.
// Optional period_o output (cycles between the last two in-gate edges) enabled by FREQ_METER_PERIOD_EN.
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sig_i,
    input  logic             start_i,
    input  logic             cont_i,
    output logic [CNT_W-1:0] count_o,
    output logic             valid_o,
    output logic             busy_o,
`ifdef FREQ_METER_PERIOD_EN
    output logic [CNT_W-1:0] period_o,
`endif
    output logic             ovf_o
);

    localparam int TW = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0]    T_LAST  = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   edge_det;
    logic [TW-1:0]          timer_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   flag_q, flag_d;
    logic                   gate_last;

    assign edge_det  = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign gate_last = (state_q == GATE) && (timer_q == T_LAST);
    assign valid_o   = (state_q == DONE);
    assign busy_o    = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i || cont_i) state_d = GATE;
            GATE:    if (timer_q == T_LAST) state_d = DONE;
            DONE:    state_d = cont_i ? GATE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Saturating edge count; the flag records an edge lost at full scale.
    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (edge_det) begin
            if (cnt_q == CNT_MAX) flag_d = 1'b1;
            else                  cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sync_q  <= '0;
            hist_q  <= 1'b0;
            timer_q <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            count_o <= '0;
            ovf_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
            hist_q  <= sync_q[SYNC_STAGES-1];
            if (state_q == GATE) begin
                timer_q <= timer_q + 1'b1;
                cnt_q   <= cnt_d;
                flag_q  <= flag_d;
            end else begin
                timer_q <= '0;
                cnt_q   <= '0;
                flag_q  <= 1'b0;
            end
            // Result registers load on the final gate cycle so they are valid alongside valid_o.
            if (gate_last) begin
                count_o <= cnt_d;
                ovf_o   <= flag_d;
            end
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    // since_q == 0 means no edge yet in this gate; it becomes 1 on the first edge.
    logic [CNT_W-1:0] since_q, per_q, per_d;

    assign per_d = (edge_det && since_q != '0) ? since_q : per_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            since_q  <= '0;
            per_q    <= '0;
            period_o <= '0;
        end else begin
            if (state_q == GATE) begin
                per_q <= per_d;
                if (edge_det)
                    since_q <= CNT_W'(1);
                else if (since_q != '0 && since_q != CNT_MAX)
                    since_q <= since_q + 1'b1;
            end else begin
                since_q <= '0;
                per_q   <= '0;
            end
            if (gate_last) period_o <= per_d;
        end
    end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: randomized and directed sig_i waveforms checked against a window-counting model.
module tb_freq_meter;

    localparam int G    = 100;
    localparam int S    = 2;
    localparam int MAXC = 20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [31:0] count;
    logic        valid, busy, ovf;
    logic [3:0]  count4;
    logic        valid4, busy4, ovf4;
`ifdef FREQ_METER_PERIOD_EN
    logic [31:0] period;
    logic [3:0]  period4;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mode = 0;   // 0: constant level, 1: square wave, 2: random bits
    int per = 10;
    int ph = 0;
    bit lvl = 1'b0;
    int last_cnt = 0;
    bit wave [0:MAXC-1];

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(32), .SYNC_STAGES(S)) dut (
        .clk_i(clk), .rst_ni(rst_n), .sig_i(sig), .start_i(start), .cont_i(cont),
        .count_o(count), .valid_o(valid), .busy_o(busy),
`ifdef FREQ_METER_PERIOD_EN
        .period_o(period),
`endif
        .ovf_o(ovf)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(S)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .sig_i(sig), .start_i(start), .cont_i(cont),
        .count_o(count4), .valid_o(valid4), .busy_o(busy4),
`ifdef FREQ_METER_PERIOD_EN
        .period_o(period4),
`endif
        .ovf_o(ovf4)
    );

    // Advance one cycle, then drive the sig_i value for the new cycle and record it.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        case (mode)
            0:       sig = lvl;
            1:       sig = ((cyc + ph) % per) < (per / 2);
            default: sig = 1'($urandom_range(0, 1));
        endcase
        if (cyc < MAXC) wave[cyc] = sig;
    endtask

    // A rising edge driven in cycle k reaches the counter in cycle k+S; gate cycles are s0+1..s0+G.
    function automatic int exp_count(input int s0);
        int n = 0;
        for (int k = s0 + 1 - S; k <= s0 + G - S; k++)
            if (wave[k] && !wave[k-1]) n++;
        return n;
    endfunction

    function automatic int exp_period(input int s0);
        int last = -1;
        int prev = -1;
        for (int k = s0 + 1 - S; k <= s0 + G - S; k++)
            if (wave[k] && !wave[k-1]) begin
                prev = last;
                last = k;
            end
        return (prev < 0) ? 0 : last - prev;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        rst_n = 1'b1;
        repeat (4) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic do_single(input string name);
        int s0, vcyc, vcnt, n, pn;
        logic [31:0] got_cnt;
        logic [3:0]  got_c4;
        logic        got_ovf, got_o4;
`ifdef FREQ_METER_PERIOD_EN
        logic [31:0] got_per;
        got_per = '0;
`endif
        got_cnt = '0; got_c4 = '0; got_ovf = 1'b0; got_o4 = 1'b0;
        repeat (6) step();
        s0 = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b want 1", name, busy); end
        vcyc = -1;
        vcnt = 0;
        for (int i = 0; i < G + 8; i++) begin
            if (cyc == s0 + G / 2) begin
                checks++;
                if (count !== 32'(last_cnt)) begin errors++; $display("FAIL %s hold: got %0d want %0d", name, count, last_cnt); end
            end
            if (valid === 1'b1) begin
                vcnt++;
                if (vcyc < 0) begin
                    vcyc = cyc; got_cnt = count; got_ovf = ovf; got_c4 = count4; got_o4 = ovf4;
`ifdef FREQ_METER_PERIOD_EN
                    got_per = period;
`endif
                end
            end
            step();
        end
        n = exp_count(s0);
        checks++; if (vcyc != s0 + G + 1) begin errors++; $display("FAIL %s latency: valid at %0d want %0d", name, vcyc, s0 + G + 1); end
        checks++; if (vcnt != 1) begin errors++; $display("FAIL %s strobes: got %0d want 1", name, vcnt); end
        checks++; if (got_cnt !== 32'(n)) begin errors++; $display("FAIL %s count: got %0d want %0d", name, got_cnt, n); end
        checks++; if (got_ovf !== 1'b0) begin errors++; $display("FAIL %s ovf: got %b want 0", name, got_ovf); end
        checks++; if (got_c4 !== 4'((n > 15) ? 15 : n)) begin errors++; $display("FAIL %s count4: got %0d want %0d", name, got_c4, (n > 15) ? 15 : n); end
        if (n != 15) begin
            checks++; if (got_o4 !== (n > 15)) begin errors++; $display("FAIL %s ovf4: got %b want %b", name, got_o4, n > 15); end
        end
`ifdef FREQ_METER_PERIOD_EN
        pn = exp_period(s0);
        checks++; if (got_per !== 32'(pn)) begin errors++; $display("FAIL %s period: got %0d want %0d", name, got_per, pn); end
`else
        pn = 0;
`endif
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_end: got %b want 0", name, busy); end
        last_cnt = n;
    endtask

    task automatic test_square();
        mode = 1; per = 10; ph = 3;
        do_single("square_p10");
    endtask

    task automatic test_const();
        mode = 0; lvl = 1'b0;
        do_single("const_low");
        lvl = 1'b1;
        do_single("const_high");
    endtask

    task automatic test_max_rate();
        mode = 1; per = 2; ph = 0;
        do_single("max_rate");
    endtask

    task automatic test_ovf();
        mode = 1; per = 5; ph = 1;
        do_single("sat_p5");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            mode = $urandom_range(1, 2);
            per  = $urandom_range(2, 23);
            ph   = $urandom_range(0, 22);
            do_single("random");
        end
    endtask

    task automatic test_cont();
        int s0, nv, n, vexp;
        mode = 1; per = 4; ph = 2;
        repeat (6) step();
        s0 = cyc;
        cont = 1'b1;
        step();
        nv = 0;
        while (cyc < s0 + 4 * (G + 1) + 6) begin
            if (cyc == s0 + 3 * (G + 1) + 50) cont = 1'b0;
            if (valid === 1'b1) begin
                vexp = s0 + (nv + 1) * (G + 1);
                n = exp_count(cyc - G - 1);
                checks++; if (cyc != vexp) begin errors++; $display("FAIL cont_latency: valid at %0d want %0d", cyc, vexp); end
                checks++; if (count !== 32'(n)) begin errors++; $display("FAIL cont_count: got %0d want %0d", count, n); end
`ifdef FREQ_METER_PERIOD_EN
                checks++; if (period !== 32'(exp_period(cyc - G - 1))) begin errors++; $display("FAIL cont_period: got %0d want %0d", period, exp_period(cyc - G - 1)); end
`endif
                last_cnt = n;
                nv++;
            end
            start = (busy === 1'b1) && ($urandom_range(0, 9) == 0);
            step();
        end
        start = 1'b0;
        checks++; if (nv != 4) begin errors++; $display("FAIL cont_strobes: got %0d want 4", nv); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int s0, nv;
        mode = 1; per = 10; ph = 0;
        repeat (6) step();
        s0 = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < s0 + 50) step();
        mode = 0; lvl = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", valid); end
        checks++; if (ovf4 !== 1'b0) begin errors++; $display("FAIL midrst_ovf4: got %b want 0", ovf4); end
        last_cnt = 0;
        nv = 0;
        for (int i = 0; i < G + 10; i++) begin
            if (valid === 1'b1) nv++;
            step();
        end
        checks++; if (nv != 0) begin errors++; $display("FAIL midrst_nostrobe: got %0d want 0", nv); end
    endtask

    initial begin
        test_reset();
        test_square();
        test_const();
        test_max_rate();
        test_ovf();
        test_random();
        test_cont();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
